// File: rtl/cla_sched_pkg.sv
// Shared types and widths for the round-robin scheduler of the shared CIM adder.
package cla_sched_pkg;
    localparam int ADD_W    = 16;
    localparam int OP_W     = 32;
    localparam int ID_MAX_W = 3;

    typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic                ci;
        logic                wide;
        logic [ID_MAX_W-1:0] id;
    } req_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    localparam int unsigned N = NREQ;

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!any && req[cand[IDW-1:0]]) begin
                any                  = 1'b1;
                idx                  = cand[IDW-1:0];
                grant[cand[IDW-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cla_rr_sched.sv
// Round-robin scheduler sharing one 16-bit adder; wide adds take LO then HI passes.
module cla_rr_sched
    import cla_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_ci,
    input  logic [NREQ-1:0]      req_wide,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_ci,
    input  logic [15:0]          add_s,
    input  logic                 add_co,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_co,
    output logic                 rsp_ovf
);
    state_t          state, state_nx;
    req_t            cur;
    logic [OP_W-1:0] sum;
    logic            carry;
    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [OP_W-1:0] a_arr [NREQ];
    logic [OP_W-1:0] b_arr [NREQ];
    logic [OP_W-1:0] sum_fmt;
    logic            msb_a, msb_b, msb_s, ovf;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*OP_W +: OP_W];
        assign b_arr[i] = req_b[i*OP_W +: OP_W];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = LO;
            LO:      state_nx = cur.wide ? HI : RSP;
            HI:      state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // req_ready is also masked by rst_n so it reads 0 while reset is held
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_ci    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (rst_n) req_ready = pick_grant;
            LO: begin
                add_a  = cur.a[ADD_W-1:0];
                add_b  = cur.b[ADD_W-1:0];
                add_ci = cur.ci;
            end
            HI: begin
                add_a  = cur.a[OP_W-1:ADD_W];
                add_b  = cur.b[OP_W-1:ADD_W];
                add_ci = carry;
            end
            RSP:     rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            sum        <= '0;
            carry      <= 1'b0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    cur.a      <= a_arr[pick_idx];
                    cur.b      <= b_arr[pick_idx];
                    cur.ci     <= req_ci[pick_idx];
                    cur.wide   <= req_wide[pick_idx];
                    cur.id     <= ID_MAX_W'(pick_idx);
                    last_grant <= pick_idx;
                end
                LO: begin
                    sum[ADD_W-1:0] <= add_s;
                    carry          <= add_co;
                end
                HI: begin
                    sum[OP_W-1:ADD_W] <= add_s;
                    carry             <= add_co;
                end
                default: ;
            endcase
        end
    end

    // Overflow uses the captured operands at the operation width
    always_comb begin
        sum_fmt = cur.wide ? sum : {{ADD_W{sum[ADD_W-1]}}, sum[ADD_W-1:0]};
        msb_a   = cur.wide ? cur.a[OP_W-1] : cur.a[ADD_W-1];
        msb_b   = cur.wide ? cur.b[OP_W-1] : cur.b[ADD_W-1];
        msb_s   = cur.wide ? sum[OP_W-1]   : sum[ADD_W-1];
        ovf     = (msb_a == msb_b) && (msb_s != msb_a);
    end

    assign rsp_id  = (state == RSP) ? cur.id[IDW-1:0] : '0;
    assign rsp_sum = (state == RSP) ? sum_fmt : '0;
    assign rsp_co  = (state == RSP) && carry;
    assign rsp_ovf = (state == RSP) && ovf;
endmodule

// File: tb/tb_cla_rr_sched.sv
// Directed bench for cla_rr_sched with a behavioural 16-bit adder on the shared port.
module tb_cla_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready, req_ci, req_wide;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [15:0]        add_a, add_b, add_s;
    logic               add_ci, add_co;
    logic               rsp_valid, rsp_ready, rsp_co, rsp_ovf;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;

    int errors = 0;
    int checks = 0;

    cla_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_wide(req_wide),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf)
    );

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_ci};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_add"}, {add_a, add_b}, 32'h0);
        check({tag, "_ctl"}, {28'h0, add_ci, rsp_valid, rsp_co, rsp_ovf}, 32'h0);
        check({tag, "_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_sum"}, rsp_sum, 32'h0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic wide);
        req_valid[i]       = 1'b1;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
        req_ci[i]          = ci;
        req_wide[i]        = wide;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] sum, input logic co,
                             input logic ovf, input logic [IDW-1:0] id);
        check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_sum"}, rsp_sum, sum);
        check({tag, "_co_ovf"}, {30'h0, rsp_co, rsp_ovf}, {30'h0, co, ovf});
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        req_ci = '0; req_wide = '0; rsp_ready = 1'b1;
        #2;
        check_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Narrow signed overflow
        set_req(0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0); #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk); req_valid = '0; #1;
        check("t1_lo_ops", {add_a, add_b}, 32'h7FFF_0001);
        check("t1_lo_ci_valid", {30'h0, add_ci, rsp_valid}, 32'h0);
        check("t1_lo_ready", 32'(req_ready), 32'h0);
        @(negedge clk); #1;
        check_rsp("t1", 32'hFFFF_8000, 1'b0, 1'b1, 2'd0);
        @(negedge clk); #1;
        check("t1_valid_drop", 32'(rsp_valid), 32'h0);

        // Wide carry propagated into HI pass
        set_req(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1); #1;
        check("t2_ready", 32'(req_ready), 32'h2);
        @(negedge clk); req_valid = '0; #1;
        check("t2_lo", {add_a, add_b}, 32'hFFFF_0001);
        check("t2_lo_ci", 32'(add_ci), 32'h0);
        @(negedge clk); #1;
        check("t2_hi", {add_a, add_b}, 32'h0);
        check("t2_hi_ci", 32'(add_ci), 32'h1);
        check("t2_hi_novalid", 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        check_rsp("t2", 32'h0001_0000, 1'b0, 1'b0, 2'd1);
        @(negedge clk); #1;

        // Wide wrap with carry-in
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1); #1;
        check("t3_ready", 32'(req_ready), 32'h4);
        @(negedge clk); req_valid = '0; #1;
        check("t3_lo_ci", 32'(add_ci), 32'h1);
        @(negedge clk); #1;
        check("t3_hi", {add_a, 15'h0, add_ci}, {16'hFFFF, 16'h0001});
        @(negedge clk); #1;
        check_rsp("t3", 32'h0000_0000, 1'b1, 1'b0, 2'd2);
        @(negedge clk); #1;

        // Reset during the HI pass of a wide op
        set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1); #1;
        check("t4_ready", 32'(req_ready), 32'h2);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        check("t4_hi_a", 32'(add_a), 32'h1234);
        rst_n = 1'b0; #1;
        check_zero("t4_rst");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        check("t4_no_rsp0", 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        check("t4_no_rsp1", 32'(rsp_valid), 32'h0);
        @(negedge clk);

        // Fairness: all requesters held valid, first grant after reset is 0
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h1000 * i + 32'h11, 32'h22, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            #1;
            check($sformatf("fair%0d_ready", n), 32'(req_ready), 32'h1 << (n % 4));
            @(negedge clk);
            @(negedge clk); #1;
            check_rsp($sformatf("fair%0d", n), 32'h1000 * (n % 4) + 32'h33, 1'b0, 1'b0,
                      IDW'(n % 4));
            @(negedge clk);
        end

        // Backpressure: response held, no grants issued meanwhile
        rsp_ready = 1'b0; #1;
        check("bp_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        @(negedge clk); #1;
        check_rsp("bp_first", 32'h2033, 1'b0, 1'b0, 2'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check_rsp($sformatf("bp_hold%0d", c), 32'h2033, 1'b0, 1'b0, 2'd2);
            check($sformatf("bp_hold%0d_ready", c), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_next_ready", 32'(req_ready), 32'h8);
        @(negedge clk);
        @(negedge clk); #1;
        check_rsp("bp_next", 32'h3033, 1'b0, 1'b0, 2'd3);
        req_valid = '0;
        @(negedge clk); #1;
        check("bp_end_valid", 32'(rsp_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
